mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
// - Multicycle MIPS-I subset core; next generation of our single-cycle processor top.
// - Control FSM, datapath and register file in one block; one unified instruction/data memory port.
// - Memory port uses a req/ready handshake, so wait-state memories are supported.
// - Illegal opcodes and (optionally) memory timeouts halt the core in a trap state.
// PARAMETERS
// - RESET_PC    32'h0000_0000  PC loaded on reset.
// - ADDR_W      32             Width of mem_addr; the low ADDR_W bits of the 32-bit address. Range 8..32.
// - WAIT_LIMIT  0              Max consecutive mem_ready=0 cycles per access; 0 = unlimited.
// PORTS
// - clk        in   1       Rising-edge clock.
// - reset      in   1       Asynchronous, active-high reset.
// - mem_req    out  1       Memory access request.
// - mem_we     out  1       1 = write, 0 = read; valid while mem_req=1.
// - mem_addr   out  ADDR_W  Byte address, word aligned.
// - mem_wdata  out  32      Store data.
// - mem_rdata  in   32      Read data; sampled on the edge where mem_ready=1.
// - mem_ready  in   1       Access completes on any edge with mem_req & mem_ready.
// - halted     out  1       Core is in TRAP.
// BEHAVIOUR
// - Reset: pc=RESET_PC, state=S_RST, all registers 0.
//   - Outputs while in reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
//   - Reset asserted mid-access aborts the access immediately; no register or PC update.
// - States and transitions:
//   - RST -> FETCH.
//   - FETCH -> DECODE.
//   - DECODE -> {MEMADR (lw/sw), EXEC (R-type), ADDIEX, BRANCH (beq), JUMP, TRAP}.
//   - MEMADR -> MEMRD | MEMWR.  MEMRD -> MEMWB.
//   - EXEC -> ALUWB.  ADDIEX -> ADDIWB.
//   - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
//   - TRAP is absorbing until reset.
// - FETCH, MEMRD and MEMWR drive mem_req=1 and hold addr/we/wdata stable until mem_ready=1.
//   - FETCH latches IR and sets pc<=pc+4 on completion; the state holds while mem_ready=0.
//   - mem_ready is ignored while mem_req=0.
// - Cycles with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, trap entry 2.
// - Supported ops:
//   - R-type funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
//   - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
//   - Any other opcode, or unknown R-type funct -> TRAP.
// - Arithmetic: 32-bit, wraps modulo 2^32, no overflow trap. slt is signed. addi sign-extends imm16.
// - Branch target = pc+4 + (sext(imm16)<<2). Jump target = {pc_plus4[31:28], imm26, 2'b00}.
// - Register file: 32x32; $0 always reads 0, writes to $0 are discarded. R-type writes rd; lw and addi write rt.
// - WAIT_LIMIT>0: a wait counter resets at each new access.
//   - If it reaches WAIT_LIMIT with mem_ready=0 -> TRAP.
//   - A pending sw is abandoned; memory must treat the dropped mem_req as cancelled.
// - halted=1 exactly while state==TRAP. mem_req=0 in TRAP.
// CONFIGURATION
// - Macro MIPS_PERF_CNT_EN.
// - Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
//   - Both reset to 0; both wrap.
//   - cycle_cnt counts every cycle after reset while not halted.
//   - instr_cnt increments on each transition back to FETCH (instruction retired).
// - Undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
// - Reset then release, mem_ready=1 -> first mem_req with mem_addr=RESET_PC in 2nd cycle after release.
// - addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1; add retires 4 cycles after its fetch.
// - sw $1,8($0) then lw $5,8($0), 3 wait states per access -> mem_we pulse at addr 8 data 5; $5=5; addr stable during waits.
// - beq taken (equal regs, imm=-1) -> refetch same address; beq not taken -> pc+4; j 0x0000040 -> fetch addr 0x100.
// - Opcode 0x3F, or funct 0x00 -> halted=1 two cycles after fetch; mem_req stays 0; reset clears halted.
// - WAIT_LIMIT=4, mem_ready held 0 -> TRAP after 4 wait cycles; reset mid-FETCH -> mem_req drops at once.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-I subset core (add/sub/and/or/slt, lw, sw,
// beq, addi, j). It has a single control FSM, a datapath and a 32x32 register file,
// all sharing one instruction/data memory port with a req/ready handshake.
// Illegal opcodes or R-type functs, and memory waits that exceed WAIT_LIMIT, halt the
// core in S_TRAP until reset.
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   mem_req/mem_we        access request; write strobe (meaningful while mem_req=1)
//   mem_addr[ADDR_W]      word-aligned byte address (low ADDR_W bits)
//   mem_wdata/mem_rdata   store data out; load/fetch data in (taken when mem_ready=1)
//   mem_ready             completes the current access
//   halted                core is in S_TRAP
// Optional feature macro MIPS_PERF_CNT_EN adds the cycle_cnt[31:0] and instr_cnt[31:0] outputs.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = 32,
  parameter int          WAIT_LIMIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;

  state_t      state;
  logic [31:0] pc, ir, aluout, mdr, wcnt;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx, rs_val, rt_val, alu_res, addr32;
  logic        funct_ok, mem_access, wait_expired;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};
  // rf[0] is reset to 0 and never written, so it always reads back as 0
  assign rs_val = rf[rs];
  assign rt_val = rf[rt];

  always_comb begin
    alu_res  = '0;
    funct_ok = 1'b1;
    case (funct)
      6'h20:   alu_res = rs_val + rt_val;
      6'h22:   alu_res = rs_val - rt_val;
      6'h24:   alu_res = rs_val & rt_val;
      6'h25:   alu_res = rs_val | rt_val;
      6'h2A:   alu_res = {31'b0, $signed(rs_val) < $signed(rt_val)};
      default: funct_ok = 1'b0;
    endcase
  end

  // Memory outputs decode straight from registered state, so reset drops them at once
  assign mem_access = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign addr32     = (state == S_FETCH) ? pc : aluout;
  assign mem_req    = mem_access;
  assign mem_we     = (state == S_MEMWR);
  assign mem_addr   = mem_access ? addr32[ADDR_W-1:0] : '0;
  assign mem_wdata  = (state == S_MEMWR) ? rt_val : '0;
  assign halted     = (state == S_TRAP);

  // wcnt counts consecutive not-ready cycles of the current access
  assign wait_expired = (WAIT_LIMIT != 0) && (wcnt == 32'(WAIT_LIMIT - 1));

`ifdef MIPS_PERF_CNT_EN
  logic retire;
  assign retire = (state inside {S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP}) ||
                  (state == S_MEMWR && mem_ready);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_RST;
      pc     <= RESET_PC;
      ir     <= '0;
      aluout <= '0;
      mdr    <= '0;
      wcnt   <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
`ifdef MIPS_PERF_CNT_EN
      cycle_cnt <= '0;
      instr_cnt <= '0;
`endif
    end else begin
      if (mem_access && !mem_ready) wcnt <= wcnt + 32'd1;
      else                          wcnt <= '0;

      case (state)
        S_RST:    state <= S_FETCH;
        S_FETCH:  if (mem_ready) begin
                    ir    <= mem_rdata;
                    pc    <= pc + 32'd4;
                    state <= S_DECODE;
                  end
        S_DECODE: case (opcode)
                    OP_RTYPE:     state <= funct_ok ? S_EXEC : S_TRAP;
                    OP_LW, OP_SW: state <= S_MEMADR;
                    OP_ADDI:      state <= S_ADDIEX;
                    OP_BEQ:       state <= S_BRANCH;
                    OP_J:         state <= S_JUMP;
                    default:      state <= S_TRAP;
                  endcase
        S_MEMADR: begin
                    aluout <= rs_val + imm_sx;
                    state  <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                  end
        S_MEMRD:  if (mem_ready) begin
                    mdr   <= mem_rdata;
                    state <= S_MEMWB;
                  end
        S_MEMWB:  begin
                    if (rt != 5'd0) rf[rt] <= mdr;
                    state <= S_FETCH;
                  end
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC:   begin
                    aluout <= alu_res;
                    state  <= S_ALUWB;
                  end
        S_ALUWB:  begin
                    if (rd != 5'd0) rf[rd] <= aluout;
                    state <= S_FETCH;
                  end
        S_ADDIEX: begin
                    aluout <= rs_val + imm_sx;
                    state  <= S_ADDIWB;
                  end
        S_ADDIWB: begin
                    if (rt != 5'd0) rf[rt] <= aluout;
                    state <= S_FETCH;
                  end
        // pc already holds pc+4 here
        S_BRANCH: begin
                    if (rs_val == rt_val) pc <= pc + (imm_sx << 2);
                    state <= S_FETCH;
                  end
        S_JUMP:   begin
                    pc    <= {pc[31:28], ir[25:0], 2'b00};
                    state <= S_FETCH;
                  end
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_TRAP;
      endcase

      // Wait timeout overrides the hold in FETCH/MEMRD/MEMWR; a pending store is dropped
      if (mem_access && !mem_ready && wait_expired) state <= S_TRAP;

`ifdef MIPS_PERF_CNT_EN
      if (state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)          instr_cnt <= instr_cnt + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench: each test loads a program, pushes the expected memory
// transactions and halt events (with their cycle numbers after reset release),
// and a negedge monitor acts as a wait-state memory and checks every event.
module tb_mips_multicycle_core;
  logic        clk = 1'b0, reset = 1'b1;
  logic        mem_req, mem_we, halted;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
`ifdef MIPS_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mips_multicycle_core #(.RESET_PC(32'h0), .ADDR_W(16), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halted(halted)
`ifdef MIPS_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 = memory access, 1 = halt entry
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wd;
  } ev_t;

  ev_t         q[$];
  logic [31:0] mem [0:255];
  int          cyc = 0, wc = 0, nwait = 0, nchk = 0, npass = 0;
  bit          allow_extra = 1'b0, hseen = 1'b0;
  logic        hold_we;
  logic [15:0] hold_addr;
  logic [31:0] hold_wd;

  function automatic void exp_ev(int kind, int c, logic we, logic [15:0] a, logic [31:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.we = we; e.addr = a; e.wd = d;
    q.push_back(e);
  endfunction

  task automatic pop_check(input int kind);
    ev_t e;
    bit  ok;
    if (q.size() == 0) begin
      if (!allow_extra) begin
        nchk++;
        $display("FAIL unexpected_event kind=%0d cyc=%0d we=%b addr=%h, none expected", kind, cyc, mem_we, mem_addr);
      end
    end else begin
      e = q.pop_front();
      nchk++;
      if (kind == 0)
        ok = (e.kind == 0) && (e.cyc == cyc) && (e.we === mem_we) && (e.addr === mem_addr) &&
             (!e.we || e.wd === mem_wdata);
      else
        ok = (e.kind == 1) && (e.cyc == cyc);
      if (ok) npass++;
      else $display("FAIL event got kind=%0d cyc=%0d we=%b addr=%h wd=%h, expected kind=%0d cyc=%0d we=%b addr=%h wd=%h",
                    kind, cyc, mem_we, mem_addr, mem_wdata, e.kind, e.cyc, e.we, e.addr, e.wd);
    end
  endtask

  // Memory responder + monitor: ready after nwait wait cycles per access
  always @(negedge clk) begin
    if (reset) begin
      cyc = 0; wc = 0; hseen = 1'b0; mem_ready = 1'b0;
    end else begin
      cyc++;
      if (halted) begin
        nchk++;
        if (mem_req !== 1'b0) $display("FAIL trap_req cyc=%0d mem_req=%b, expected 0", cyc, mem_req);
        else npass++;
        if (!hseen) begin hseen = 1'b1; pop_check(1); end
      end
      if (mem_req) begin
        if (wc == 0) begin
          hold_we = mem_we; hold_addr = mem_addr; hold_wd = mem_wdata;
        end else begin
          nchk++;
          if (mem_we !== hold_we || mem_addr !== hold_addr || (hold_we && mem_wdata !== hold_wd))
            $display("FAIL wait_stable cyc=%0d we=%b addr=%h wd=%h, expected we=%b addr=%h wd=%h",
                     cyc, mem_we, mem_addr, mem_wdata, hold_we, hold_addr, hold_wd);
          else npass++;
        end
        if (wc >= nwait) begin
          mem_rdata = mem[mem_addr[9:2]];
          if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
          pop_check(0);
          mem_ready = 1'b1; wc = 0;
        end else begin
          mem_ready = 1'b0; wc++;
        end
      end else mem_ready = 1'b0;
    end
  end

  task automatic hold_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 nchk++;
    if ({mem_req, mem_we, halted} !== 3'b000 || mem_addr !== 16'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_outputs req=%b we=%b halted=%b addr=%h wd=%h, expected all 0",
               mem_req, mem_we, halted, mem_addr, mem_wdata);
    else npass++;
    q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 32'hFC00_0000;
  endtask

  task automatic put(input int a, input logic [31:0] instr);
    mem[a >> 2] = instr;
  endtask

  task automatic release_rst(input int nw, input bit allow);
    nwait = nw; allow_extra = allow;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
    nchk++;
    if (q.size() != 0) $display("FAIL timeout pending=%0d events, expected 0", q.size());
    else npass++;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    // ---- Test 1: ALU ops, sw/lw, beq both ways, j, $0, opcode 0x3F trap ----
    hold_reset();
    put(32'h00, 32'h2001_0005); put(32'h04, 32'h2002_FFFD); put(32'h08, 32'h0022_1820);
    put(32'h0C, 32'h0041_202A); put(32'h10, 32'hAC03_0080); put(32'h14, 32'hAC04_0084);
    put(32'h18, 32'h0022_3022); put(32'h1C, 32'h0022_3824); put(32'h20, 32'h0022_4025);
    put(32'h24, 32'h0022_482A); put(32'h28, 32'hAC06_0088); put(32'h2C, 32'hAC07_008C);
    put(32'h30, 32'hAC08_0090); put(32'h34, 32'hAC09_0094); put(32'h38, 32'h8C05_0080);
    put(32'h3C, 32'hAC05_0098); put(32'h40, 32'h1022_0005); put(32'h44, 32'h0800_0040);
    put(32'h100, 32'h200A_0007); put(32'h104, 32'h1021_0001); put(32'h10C, 32'hAC0A_009C);
    put(32'h110, 32'h2000_0009); put(32'h114, 32'hAC00_00A0);
    exp_ev(0,  2, 0, 16'h00, 0); exp_ev(0,  6, 0, 16'h04, 0); exp_ev(0, 10, 0, 16'h08, 0);
    exp_ev(0, 14, 0, 16'h0C, 0); exp_ev(0, 18, 0, 16'h10, 0); exp_ev(0, 21, 1, 16'h80, 32'd2);
    exp_ev(0, 22, 0, 16'h14, 0); exp_ev(0, 25, 1, 16'h84, 32'd1); exp_ev(0, 26, 0, 16'h18, 0);
    exp_ev(0, 30, 0, 16'h1C, 0); exp_ev(0, 34, 0, 16'h20, 0); exp_ev(0, 38, 0, 16'h24, 0);
    exp_ev(0, 42, 0, 16'h28, 0); exp_ev(0, 45, 1, 16'h88, 32'd8); exp_ev(0, 46, 0, 16'h2C, 0);
    exp_ev(0, 49, 1, 16'h8C, 32'd5); exp_ev(0, 50, 0, 16'h30, 0);
    exp_ev(0, 53, 1, 16'h90, 32'hFFFF_FFFD); exp_ev(0, 54, 0, 16'h34, 0);
    exp_ev(0, 57, 1, 16'h94, 32'd0); exp_ev(0, 58, 0, 16'h38, 0); exp_ev(0, 61, 0, 16'h80, 0);
    exp_ev(0, 63, 0, 16'h3C, 0); exp_ev(0, 66, 1, 16'h98, 32'd2); exp_ev(0, 67, 0, 16'h40, 0);
    exp_ev(0, 70, 0, 16'h44, 0); exp_ev(0, 73, 0, 16'h100, 0); exp_ev(0, 77, 0, 16'h104, 0);
    exp_ev(0, 80, 0, 16'h10C, 0); exp_ev(0, 83, 1, 16'h9C, 32'd7); exp_ev(0, 84, 0, 16'h110, 0);
    exp_ev(0, 88, 0, 16'h114, 0); exp_ev(0, 91, 1, 16'hA0, 32'd0); exp_ev(0, 92, 0, 16'h118, 0);
    exp_ev(1, 94, 0, 16'h0, 0);
    release_rst(0, 0);
    wait_done(200);

    // ---- Test 2: sw/lw with 3 wait states per access ----
    hold_reset();
    put(32'h00, 32'h0800_0040); put(32'h100, 32'h2001_0005); put(32'h104, 32'hAC01_0008);
    put(32'h108, 32'h8C05_0008); put(32'h10C, 32'hAC05_0040);
    exp_ev(0,  5, 0, 16'h00, 0); exp_ev(0, 11, 0, 16'h100, 0); exp_ev(0, 18, 0, 16'h104, 0);
    exp_ev(0, 24, 1, 16'h08, 32'd5); exp_ev(0, 28, 0, 16'h108, 0); exp_ev(0, 34, 0, 16'h08, 0);
    exp_ev(0, 39, 0, 16'h10C, 0); exp_ev(0, 45, 1, 16'h40, 32'd5); exp_ev(0, 49, 0, 16'h110, 0);
    exp_ev(1, 51, 0, 16'h0, 0);
    release_rst(3, 0);
    wait_done(200);

    // ---- Test 3: beq taken with imm=-1 refetches the same address ----
    hold_reset();
    put(32'h00, 32'h1000_FFFF);
    exp_ev(0, 2, 0, 16'h00, 0); exp_ev(0, 5, 0, 16'h00, 0); exp_ev(0, 8, 0, 16'h00, 0);
    release_rst(0, 1);
    wait_done(50);

    // ---- Test 4: unknown funct 0x00 traps two cycles after fetch ----
    hold_reset();
    put(32'h00, 32'h0000_0000);
    exp_ev(0, 2, 0, 16'h00, 0); exp_ev(1, 4, 0, 16'h0, 0);
    release_rst(0, 0);
    wait_done(50);

    // ---- Test 5: fetch never ready, WAIT_LIMIT=4 -> trap after 4 wait cycles ----
    hold_reset();
    exp_ev(1, 6, 0, 16'h0, 0);
    release_rst(1000, 0);
    wait_done(50);

    // ---- Test 6: reset asserted mid-FETCH drops mem_req immediately ----
    hold_reset();
    release_rst(1000, 0);
    @(posedge clk); #3;
    nchk++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0)
      $display("FAIL midfetch_req req=%b addr=%h, expected req=1 addr=0000", mem_req, mem_addr);
    else npass++;
    reset = 1'b1; #1;
    nchk++;
    if ({mem_req, mem_we, halted} !== 3'b000 || mem_addr !== 16'h0)
      $display("FAIL midfetch_abort req=%b we=%b halted=%b addr=%h, expected all 0",
               mem_req, mem_we, halted, mem_addr);
    else npass++;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
